// File: rtl/m_arb3.sv
// Three-sink, one-source merging arbiter: each valid-only sink feeds a small FIFO,
// and a round-robin arbiter drains one FIFO head per cycle into a registered output.
module m_arb3 #(
    parameter int WORD_BITS  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_BITS-1:0] iSnk0Data,
    input  logic                 iSnk0Valid,
    input  logic [WORD_BITS-1:0] iSnk1Data,
    input  logic                 iSnk1Valid,
    input  logic [WORD_BITS-1:0] iSnk2Data,
    input  logic                 iSnk2Valid,
    output logic [WORD_BITS-1:0] oSrc0Data,
    output logic                 oSrc0Valid
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    logic [WORD_BITS-1:0] snkData [3];
    logic [2:0]           snkValid;

    logic [WORD_BITS-1:0] mem [3][FIFO_DEPTH];
    logic [AW-1:0]        wrPtr [3];
    logic [AW-1:0]        rdPtr [3];
    logic [AW:0]          count [3];

    logic [1:0] lastGrant;
    logic [1:0] grantIdx;
    logic       grantValid;
    logic [1:0] cand0, cand1, cand2;
    logic [2:0] notEmpty;
    logic [2:0] push;
    logic [2:0] pop;

    assign snkData[0] = iSnk0Data;
    assign snkData[1] = iSnk1Data;
    assign snkData[2] = iSnk2Data;
    assign snkValid   = {iSnk2Valid, iSnk1Valid, iSnk0Valid};

    function automatic logic [1:0] nextIdx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Round-robin pick over FIFO occupancy as it stood before this edge's writes.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = lastGrant;
        cand0      = nextIdx(lastGrant);
        cand1      = nextIdx(cand0);
        cand2      = nextIdx(cand1);
        for (int i = 0; i < 3; i++) begin
            notEmpty[i] = (count[i] != '0);
        end
        if (notEmpty[cand0]) begin
            grantValid = 1'b1;
            grantIdx   = cand0;
        end else if (notEmpty[cand1]) begin
            grantValid = 1'b1;
            grantIdx   = cand1;
        end else if (notEmpty[cand2]) begin
            grantValid = 1'b1;
            grantIdx   = cand2;
        end
    end

    // A full FIFO still accepts a word when its head leaves in the same cycle.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            pop[i]  = grantValid && (grantIdx == 2'(i));
            push[i] = snkValid[i] && ((count[i] != FULL_COUNT) || pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst && push[i]) begin
                mem[i][wrPtr[i]] <= snkData[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                wrPtr[i] <= '0;
                rdPtr[i] <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push[i]) begin
                    wrPtr[i] <= wrPtr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rdPtr[i] <= rdPtr[i] + 1'b1;
                end
                count[i] <= count[i] + {{AW{1'b0}}, push[i]} - {{AW{1'b0}}, pop[i]};
            end
        end
    end

    // Last grant resets to 2 so that sink 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant  <= 2'd2;
            oSrc0Valid <= 1'b0;
            oSrc0Data  <= '0;
        end else if (grantValid) begin
            lastGrant  <= grantIdx;
            oSrc0Valid <= 1'b1;
            oSrc0Data  <= mem[grantIdx][rdPtr[grantIdx]];
        end else begin
            oSrc0Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_m_arb3.sv
// Directed self-checking bench for m_arb3: a vector table for reset, simultaneous
// arrivals and mid-burst reset, plus hand sequences for streaming and round-robin overload.
module tb_m_arb3;

    logic        clk;
    logic        rst;
    logic [31:0] iSnk0Data, iSnk1Data, iSnk2Data;
    logic        iSnk0Valid, iSnk1Valid, iSnk2Valid;
    logic [31:0] oSrc0Data;
    logic        oSrc0Valid;

    int compared;
    int mismatched;

    typedef struct {
        logic        rst;
        logic [2:0]  v;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        expValid;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[$];

    m_arb3 #(.WORD_BITS(32), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .iSnk0Data  (iSnk0Data),
        .iSnk0Valid (iSnk0Valid),
        .iSnk1Data  (iSnk1Data),
        .iSnk1Valid (iSnk1Valid),
        .iSnk2Data  (iSnk2Data),
        .iSnk2Valid (iSnk2Valid),
        .oSrc0Data  (oSrc0Data),
        .oSrc0Valid (oSrc0Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [31:0] d0,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic ev, input logic [31:0] ed);
        vec_t t;
        t.rst = r; t.v = v; t.d0 = d0; t.d1 = d1; t.d2 = d2;
        t.expValid = ev; t.expData = ed;
        return t;
    endfunction

    // Drive one cycle of inputs, then move just past the capturing edge.
    task automatic applyStimulus(input logic r, input logic [2:0] v, input logic [31:0] d0,
                                 input logic [31:0] d1, input logic [31:0] d2);
        rst = r;
        iSnk0Valid = v[0]; iSnk0Data = d0;
        iSnk1Valid = v[1]; iSnk1Data = d1;
        iSnk2Valid = v[2]; iSnk2Data = d2;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic expValid, input logic [31:0] expData);
        compared++;
        if (oSrc0Valid !== expValid) begin
            mismatched++;
            $display("[TB] FAIL %s valid: got %b expected %b", name, oSrc0Valid, expValid);
        end
        compared++;
        if (oSrc0Data !== expData) begin
            mismatched++;
            $display("[TB] FAIL %s data: got 0x%08h expected 0x%08h", name, oSrc0Data, expData);
        end
    endtask

    int s0[11] = '{1, 2, 3, 4, 5, 6, 8, 11, 14, 17, 20};
    int s1[10] = '{1, 2, 3, 4, 5, 6, 9, 12, 15, 18};
    int s2[10] = '{1, 2, 3, 4, 5, 7, 10, 13, 16, 19};

    initial begin
        logic [31:0] expD;
        logic [31:0] held;
        int          k;
        compared = 0;
        mismatched = 0;
        rst = 1'b1;
        iSnk0Valid = 1'b0; iSnk1Valid = 1'b0; iSnk2Valid = 1'b0;
        iSnk0Data = '0; iSnk1Data = '0; iSnk2Data = '0;

        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 3'b001, 32'hAA, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 3'b111, 32'h10, 32'h20, 32'h30, 0, 32'h0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 32'h10));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 32'h20));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 32'h30));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 32'h30));
        vecs.push_back(mk(0, 3'b111, 32'hA0, 32'hB0, 32'hC0, 0, 32'h30));
        vecs.push_back(mk(0, 3'b111, 32'hA1, 32'hB1, 32'hC1, 1, 32'hA0));
        vecs.push_back(mk(1, 3'b111, 32'hA2, 32'hB2, 32'hC2, 0, 32'h0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 32'h0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].d0, vecs[i].d1, vecs[i].d2);
            checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expData);
        end

        // Single stream per sink, switching sink every 10 cycles.
        for (int e = 1; e <= 32; e++) begin
            logic [2:0]  v;
            logic [31:0] c;
            c = 32'(e);
            v = 3'b000;
            if (e <= 10) v = 3'b001;
            else if (e <= 20) v = 3'b010;
            else if (e <= 30) v = 3'b100;
            applyStimulus(0, v, c, c << 2, c << 4);
            if (e == 1) begin
                checkOutput("stream_start", 0, 32'h0);
            end else if (e <= 31) begin
                c = 32'(e - 1);
                expD = (e - 1 <= 10) ? c : ((e - 1 <= 20) ? (c << 2) : (c << 4));
                checkOutput($sformatf("stream%0d", e - 1), 1, expD);
            end else begin
                checkOutput("stream_end", 0, 32'd30 << 4);
            end
        end

        applyStimulus(1, 3'b000, 0, 0, 0);
        checkOutput("rr_reset", 0, 32'h0);

        // All sinks every cycle for 20 cycles: rotation 0,1,2 with overflow drops.
        held = 32'h0;
        for (int e = 1; e <= 33; e++) begin
            logic [31:0] c;
            c = 32'(e);
            if (e <= 20) applyStimulus(0, 3'b111, 32'h100 | c, 32'h200 | c, 32'h300 | c);
            else         applyStimulus(0, 3'b000, 0, 0, 0);
            if (e == 1 || e == 33) begin
                checkOutput($sformatf("rr_idle%0d", e), 0, held);
            end else begin
                k = e - 2;
                case (k % 3)
                    0:       expD = 32'h100 | 32'(s0[k / 3]);
                    1:       expD = 32'h200 | 32'(s1[k / 3]);
                    default: expD = 32'h300 | 32'(s2[k / 3]);
                endcase
                held = expD;
                checkOutput($sformatf("rr_out%0d", k), 1, expD);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/m_arb3.md
Name:
m_arb3

Overview:
- Three-input, one-output arbiter for valid-only streams (no ready/backpressure).
- Each sink port has a small FIFO; a round-robin arbiter drains the FIFOs into one registered source port at up to one word per cycle.
- Used to merge three independent 32-bit producers onto a single downstream channel.

Parameters:
- WORD_BITS, 32, data width of every sink and source port.
- FIFO_DEPTH, 4, entries per sink FIFO; must be a power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- iSnk0Data  in  WORD_BITS  sink 0 data.
- iSnk0Valid  in  1  sink 0 word present this cycle.
- iSnk1Data  in  WORD_BITS  sink 1 data.
- iSnk1Valid  in  1  sink 1 word present this cycle.
- iSnk2Data  in  WORD_BITS  sink 2 data.
- iSnk2Valid  in  1  sink 2 word present this cycle.
- oSrc0Data  out  WORD_BITS  merged output data, registered.
- oSrc0Valid  out  1  merged output valid, registered.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset, while rst=1 at a rising edge:
  - all FIFOs are emptied (pointers and counts go to 0);
  - oSrc0Valid=0 and oSrc0Data=0;
  - the round-robin last-grant pointer is set to 2, so sink 0 has top priority first.
  - Valid inputs presented while rst=1 are discarded.
- Sink capture:
  - At each edge with iSnkNValid=1 and rst=0, iSnkNData is written to FIFO N.
  - Write while full with no pop in the same cycle: the incoming word is silently dropped and the FIFO contents are unchanged.
  - Write while full with a pop of that FIFO in the same cycle: the write is accepted and the count stays at FIFO_DEPTH.
- Arbitration, evaluated every cycle on FIFO state before this edge's writes:
  - The candidates are the non-empty FIFOs.
  - Search order starts at (last_grant+1) mod 3 and wraps.
  - The first non-empty FIFO in that order is granted. Its head is popped and loaded into oSrc0Data, oSrc0Valid is set to 1, and last_grant takes the granted index.
  - If no FIFO is non-empty: oSrc0Valid=0, oSrc0Data holds its previous value, and last_grant is unchanged.
- Latency: a word written at edge N reaches the output register at edge N+1 at the earliest, so it is visible on the outputs 2 cycles after it was presented.
- Throughput:
  - One output word per cycle in total.
  - A single active sink streaming every cycle passes through loss-free with constant 2-cycle latency and oSrc0Valid continuously 1.
- Fairness: with all three FIFOs non-empty, grants rotate 0,1,2,0,... Words within one sink are never reordered.
- Overload: aggregate input above 1 word/cycle eventually fills FIFOs, and words are then dropped per the rule above. No error signal.
- Width: data passes through unmodified, with no arithmetic.
- Counts: FIFO counts are log2(FIFO_DEPTH)+1 bits wide. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: all buffered words are lost. Output is 0/invalid on the following cycle.

Test Plan:
- Reset: hold rst=1 for 4 cycles with iSnk0Valid=1 -> oSrc0Valid=0 and oSrc0Data=0 throughout reset and on the first cycle after rst falls; no sink 0 word appears on the output before the second cycle after rst falls.
- Single stream: iSnk0Valid=1 continuously, iSnk0Data=a counting 1,2,3,... -> oSrc0Data=a with 2-cycle latency, oSrc0Valid=1 every cycle, no gaps or drops.
- Channel switch: sink 0 stream stops and sink 1 starts at the next cycle with data a<<2 (e.g. a=200 -> 800) -> output switches to sink 1 values with no lost words, then the same for sink 2 with data a<<4 (a=300 -> 4800).
- Simultaneous: in one cycle, sink0=0x10, sink1=0x20, sink2=0x30 valid, then idle -> outputs 0x10, 0x20, 0x30 on three consecutive cycles, then oSrc0Valid=0.
- Round-robin: all three sinks valid every cycle for 20 cycles -> output source order is strictly 0,1,2 repeating; each FIFO fills and excess words are dropped, while the per-sink order of delivered words is preserved.
- Reset mid-burst: with FIFOs holding data, assert rst for 1 cycle -> oSrc0Valid=0 and oSrc0Data=0 afterwards; no pre-reset words ever appear on the output.
